alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  decode presents an operation.
REQ-005 in_ready  output  1  sequencer can accept an operation.
REQ-006 in_mat  input  1  1 = 4x4 matrix operation (16 elements); 0 = scalar (1 element).
REQ-007 in_rd  input  5  destination register index, carried to the output.
REQ-008 lane_valid  output  1  request to the shared 32-bit execute lane.
REQ-009 lane_i, lane_j  output  2 each  element row and column presented to the lane (matI/matJ).
REQ-010 lane_done  input  1  lane result valid this cycle; one-cycle pulse.
REQ-011 lane_res  input  32  lane result for the current element.
REQ-012 out_valid  output  1  assembled result available.
REQ-013 out_ready  input  1  writeback accepts the result.
REQ-014 out_res_M  output  512  result buffer; element k=4*i+j occupies bits [32k+31:32k].
REQ-015 out_rd  output  5  captured in_rd.
REQ-016 out_mat  output  1  captured in_mat.
REQ-017 flush  input  1  synchronous abort.
REQ-018 op_count  output  32  number of completed output handshakes.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 IDLE: in_ready=1, lane_valid=0, out_valid=0; when in_valid=1, capture in_rd and in_mat, clear out_res_M to 0, set i=j=0, and go to RUN.
REQ-021 in_ready SHALL be 1 only in IDLE; no operation is accepted in the same cycle as an output handshake.
REQ-022 RUN: lane_valid=1 with lane_i=i and lane_j=j, held stable until lane_done.
REQ-023 On lane_done in RUN, lane_res SHALL be written to element 4*i+j of out_res_M in that edge.
REQ-024 Scalar op: after the first lane_done, go to DONE; bits 511:32 remain 0.
REQ-025 Matrix op: j SHALL increment on each lane_done; when j wraps 3->0, i SHALL increment; after the element (i=3, j=3) is written, go to DONE.
REQ-026 lane_done while not in RUN SHALL be ignored.
REQ-027 DONE: out_valid=1; out_res_M, out_rd and out_mat held stable; when out_ready=1, go to IDLE and increment op_count.
REQ-028 op_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 Minimum latency: accept at edge T, lane_valid high from T+1; with lane_done every cycle, out_valid is high at T+2 (scalar) or T+17 (matrix).
REQ-030 flush=1 SHALL force IDLE at the next edge from any state and discard any in-flight result.
REQ-031 flush SHALL have priority over in_valid, lane_done and out_ready in the same cycle.
REQ-032 op_count SHALL NOT increment on the flush cycle, even if out_ready=1.
REQ-033 out_res_M contents after a flush are don't-care until the next accept.

Reset
REQ-034 While rst_n=0: state=IDLE, i=j=0, out_res_M=0, out_rd=0, out_mat=0, op_count=0, out_valid=0, lane_valid=0, in_ready=1.
REQ-035 Reset asserted mid-RUN or in DONE SHALL abandon the operation immediately and asynchronously.
REQ-036 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-037 Scalar: in_valid, in_mat=0, in_rd=5, then lane_done with lane_res=0x12345678 -> out_valid two cycles after accept, out_res_M[31:0]=0x12345678, upper bits 0, out_rd=5; out_ready=1 -> op_count=1.
REQ-038 Matrix: in_mat=1, lane_done every cycle with lane_res=k for element k -> lane_i/lane_j sequence (0,0),(0,1)...(3,3); element k equals k; out_valid high 17 cycles after accept.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid and data stable, in_ready=0, no new accept; release -> IDLE, op_count increments once.
REQ-040 Lane stall: matrix op with lane_done every 3rd cycle -> lane_i/lane_j stable between pulses; 16 writes total; spurious lane_done in IDLE has no effect.
REQ-041 Flush: assert flush at element (2,1), together with lane_done -> IDLE next cycle, out_valid never rises, op_count unchanged; flush in DONE with out_ready=1 -> no increment.
REQ-042 Reset: drop rst_n mid-RUN -> all outputs at reset values without waiting for a clock edge; op_count preset to 0xFFFFFFFF via repeated ops wraps to 0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequences scalar or 4x4 matrix ops through a shared 32-bit lane,
// assembling per-element results into a 512-bit buffer for writeback.
module alu_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mat,
  input  logic [4:0]   in_rd,
  output logic         lane_valid,
  output logic [1:0]   lane_i,
  output logic [1:0]   lane_j,
  input  logic         lane_done,
  input  logic [31:0]  lane_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_res_M,
  output logic [4:0]   out_rd,
  output logic         out_mat,
  input  logic         flush,
  output logic [31:0]  op_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] i_q, i_d, j_q, j_d;
  logic [511:0] res_q, res_d;
  logic [4:0] rd_q, rd_d;
  logic mat_q, mat_d;
  logic [31:0] op_count_q, op_count_d;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    res_d = res_q;
    rd_d = rd_q;
    mat_d = mat_q;
    op_count_d = op_count_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      rd_d = in_rd;
      mat_d = in_mat;
      res_d = '0;
      i_d = 2'd0;
      j_d = 2'd0;
    end else if (state_q == RUN && lane_done) begin
      // element k = 4*i+j lives at bit offset 32*k = {i,j,5'b0}
      res_d[{i_q, j_q, 5'd0} +: 32] = lane_res;
      j_d = j_q + 2'd1;
      i_d = (j_q == 2'd3) ? i_q + 2'd1 : i_q;
      if (!mat_q || {i_q, j_q} == 4'hf) state_d = DONE;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      op_count_d = op_count_q + 32'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= 2'd0;
      j_q <= 2'd0;
      res_q <= '0;
      rd_q <= 5'd0;
      mat_q <= 1'b0;
      op_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      res_q <= res_d;
      rd_q <= rd_d;
      mat_q <= mat_d;
      op_count_q <= op_count_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign lane_valid = state_q == RUN;
  assign out_valid = state_q == DONE;
  assign lane_i = i_q;
  assign lane_j = j_q;
  assign out_res_M = res_q;
  assign out_rd = rd_q;
  assign out_mat = mat_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; expected results are queued at
// accept and compared when the sequencer presents its output.
module tb_alu_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, in_mat = 0, lane_done = 0, out_ready = 0, flush = 0;
  logic [4:0] in_rd = 0;
  logic [31:0] lane_res = 0;
  logic in_ready, lane_valid, out_valid, out_mat;
  logic [1:0] lane_i, lane_j;
  logic [511:0] out_res_M;
  logic [4:0] out_rd;
  logic [31:0] op_count;
  int total = 0, bad = 0;
  logic [31:0] exp_cnt = 0;
  typedef struct {logic [4:0] rd; logic mat; logic [511:0] res;} exp_t;
  exp_t sb[$];

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
    .in_rd(in_rd), .lane_valid(lane_valid), .lane_i(lane_i), .lane_j(lane_j),
    .lane_done(lane_done), .lane_res(lane_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_res_M(out_res_M), .out_rd(out_rd), .out_mat(out_mat), .flush(flush), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic mat, input logic [4:0] rd);
    in_valid = 1; in_mat = mat; in_rd = rd;
    tick();
    in_valid = 0;
  endtask

  task automatic lane(input logic [31:0] v);
    lane_done = 1; lane_res = v;
    tick();
    lane_done = 0;
  endtask

  task automatic push_scalar(input logic [4:0] rd, input logic [31:0] v);
    exp_t e;
    e.rd = rd; e.mat = 0; e.res = '0; e.res[31:0] = v;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 0;
    #2;
    total++;
    if ({in_ready, lane_valid, out_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100", {in_ready, lane_valid, out_valid});
    end
    total++;
    if (op_count !== 0 || out_res_M !== 0 || out_rd !== 0 || out_mat !== 0) begin
      bad++; $display("FAIL reset_data op_count=%h rd=%h mat=%b res_nonzero=%b exp all 0", op_count, out_rd, out_mat, |out_res_M);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic test_scalar;
    exp_t e;
    push_scalar(5, 32'h12345678);
    accept(0, 5);
    total++;
    if (lane_valid !== 1 || lane_i !== 0 || lane_j !== 0 || out_valid !== 0 || in_ready !== 0) begin
      bad++; $display("FAIL scalar_run lv=%b i=%0d j=%0d ov=%b ir=%b exp 1 0 0 0 0", lane_valid, lane_i, lane_j, out_valid, in_ready);
    end
    lane(32'h12345678);
    total++;
    if (out_valid !== 1) begin bad++; $display("FAIL scalar_latency out_valid=%b exp=1", out_valid); end
    e = sb.pop_front();
    total++;
    if (out_res_M !== e.res || out_rd !== e.rd || out_mat !== e.mat) begin
      bad++; $display("FAIL scalar_data res=%h rd=%0d mat=%b exp res=%h rd=%0d mat=%b", out_res_M, out_rd, out_mat, e.res, e.rd, e.mat);
    end
    out_ready = 1; tick(); out_ready = 0; exp_cnt++;
    total++;
    if (op_count !== exp_cnt || out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL scalar_handshake op_count=%0d ov=%b ir=%b exp %0d 0 1", op_count, out_valid, in_ready, exp_cnt);
    end
  endtask

  task automatic test_matrix(input int gap, input logic [4:0] rd);
    exp_t e;
    int errs = 0;
    e.rd = rd; e.mat = 1; e.res = '0;
    for (int k = 0; k < 16; k++) e.res[32*k +: 32] = gap * 32'h100 + k;
    sb.push_back(e);
    accept(1, rd);
    for (int k = 0; k < 16; k++) begin
      repeat (gap) begin
        if (lane_valid !== 1 || lane_i !== k[3:2] || lane_j !== k[1:0] || out_valid !== 0) errs++;
        tick();
      end
      if (lane_valid !== 1 || lane_i !== k[3:2] || lane_j !== k[1:0] || out_valid !== 0) errs++;
      lane(gap * 32'h100 + k);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL matrix_seq gap=%0d errors=%0d exp=0", gap, errs); end
    total++;
    if (out_valid !== 1) begin bad++; $display("FAIL matrix_latency gap=%0d out_valid=%b exp=1", gap, out_valid); end
    e = sb.pop_front();
    total++;
    if (out_res_M !== e.res || out_rd !== e.rd || out_mat !== e.mat) begin
      bad++; $display("FAIL matrix_data res=%h rd=%0d mat=%b exp res=%h rd=%0d mat=%b", out_res_M, out_rd, out_mat, e.res, e.rd, e.mat);
    end
    lane(32'hFFFF_FFFF);
    total++;
    if (out_res_M !== e.res || out_valid !== 1) begin
      bad++; $display("FAIL done_spurious res=%h ov=%b exp res=%h ov=1", out_res_M, out_valid, e.res);
    end
    out_ready = 1; tick(); out_ready = 0; exp_cnt++;
    lane(32'h0000_0BAD);
    total++;
    if (in_ready !== 1 || lane_valid !== 0 || out_valid !== 0 || op_count !== exp_cnt) begin
      bad++; $display("FAIL idle_spurious ir=%b lv=%b ov=%b op_count=%0d exp 1 0 0 %0d", in_ready, lane_valid, out_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int errs = 0;
    push_scalar(9, 32'hDEAD_BEEF);
    accept(0, 9);
    lane(32'hDEAD_BEEF);
    e = sb.pop_front();
    in_valid = 1; in_mat = 1; in_rd = 3;
    repeat (5) begin
      tick();
      if (out_valid !== 1 || in_ready !== 0 || lane_valid !== 0 || out_res_M !== e.res || out_rd !== e.rd || out_mat !== e.mat) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL bp_hold errors=%0d exp=0", errs); end
    out_ready = 1; tick(); out_ready = 0; exp_cnt++;
    total++;
    if (in_ready !== 1 || lane_valid !== 0 || out_valid !== 0 || op_count !== exp_cnt) begin
      bad++; $display("FAIL bp_release ir=%b lv=%b ov=%b op_count=%0d exp 1 0 0 %0d", in_ready, lane_valid, out_valid, op_count, exp_cnt);
    end
    in_valid = 0;
    tick();
    total++;
    if (in_ready !== 1 || op_count !== exp_cnt) begin
      bad++; $display("FAIL bp_once ir=%b op_count=%0d exp 1 %0d", in_ready, op_count, exp_cnt);
    end
  endtask

  task automatic test_flush;
    exp_t e;
    int errs = 0;
    e.rd = 7; e.mat = 1; e.res = '0;
    sb.push_back(e);
    accept(1, 7);
    for (int k = 0; k < 9; k++) lane(k);
    total++;
    if (lane_i !== 2 || lane_j !== 1) begin bad++; $display("FAIL flush_pos i=%0d j=%0d exp 2 1", lane_i, lane_j); end
    flush = 1; lane_done = 1; lane_res = 9; out_ready = 1;
    tick();
    flush = 0; lane_done = 0; out_ready = 0;
    sb.delete();
    total++;
    if (in_ready !== 1 || lane_valid !== 0 || out_valid !== 0 || op_count !== exp_cnt) begin
      bad++; $display("FAIL flush_run ir=%b lv=%b ov=%b op_count=%0d exp 1 0 0 %0d", in_ready, lane_valid, out_valid, op_count, exp_cnt);
    end
    repeat (10) begin tick(); if (out_valid !== 0) errs++; end
    total++;
    if (errs != 0) begin bad++; $display("FAIL flush_quiet errors=%0d exp=0", errs); end
    in_valid = 1; in_mat = 0; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    total++;
    if (lane_valid !== 0 || in_ready !== 1) begin bad++; $display("FAIL flush_idle lv=%b ir=%b exp 0 1", lane_valid, in_ready); end
    push_scalar(2, 32'h77);
    accept(0, 2);
    lane(32'h77);
    total++;
    if (out_valid !== 1) begin bad++; $display("FAIL flush_predone out_valid=%b exp=1", out_valid); end
    flush = 1; out_ready = 1;
    tick();
    flush = 0; out_ready = 0;
    sb.delete();
    total++;
    if (op_count !== exp_cnt || out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL flush_done op_count=%0d ov=%b ir=%b exp %0d 0 1", op_count, out_valid, in_ready, exp_cnt);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    accept(1, 12);
    for (int k = 1; k < 6; k++) lane(k);
    #2 rst_n = 0;
    #1;
    sb.delete(); exp_cnt = 0;
    total++;
    if ({in_ready, lane_valid, out_valid} !== 3'b100 || lane_i !== 0 || lane_j !== 0) begin
      bad++; $display("FAIL async_ctrl got=%b i=%0d j=%0d exp=100 0 0", {in_ready, lane_valid, out_valid}, lane_i, lane_j);
    end
    total++;
    if (op_count !== 0 || out_res_M !== 0 || out_rd !== 0 || out_mat !== 0) begin
      bad++; $display("FAIL async_data op_count=%h rd=%h mat=%b res_nonzero=%b exp all 0", op_count, out_rd, out_mat, |out_res_M);
    end
    @(posedge clk);
    #3 rst_n = 1;
    push_scalar(1, 32'hA5A5_A5A5);
    accept(0, 1);
    total++;
    if (lane_valid !== 1 || in_ready !== 0) begin bad++; $display("FAIL first_accept lv=%b ir=%b exp 1 0", lane_valid, in_ready); end
    lane(32'hA5A5_A5A5);
    e = sb.pop_front();
    total++;
    if (out_valid !== 1 || out_res_M !== e.res || out_rd !== e.rd) begin
      bad++; $display("FAIL post_reset_data ov=%b res=%h rd=%0d exp 1 res=%h rd=%0d", out_valid, out_res_M, out_rd, e.res, e.rd);
    end
    out_ready = 1; tick(); out_ready = 0; exp_cnt++;
    total++;
    if (op_count !== exp_cnt) begin bad++; $display("FAIL post_reset_count op_count=%0d exp=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_wrap;
    force dut.op_count_q = 32'hFFFF_FFFF;
    tick();
    tick();
    release dut.op_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    total++;
    if (op_count !== exp_cnt) begin bad++; $display("FAIL wrap_preset op_count=%h exp=%h", op_count, exp_cnt); end
    push_scalar(4, 32'h0BEE_F000);
    accept(0, 4);
    lane(32'h0BEE_F000);
    void'(sb.pop_front());
    out_ready = 1; tick(); out_ready = 0; exp_cnt++;
    total++;
    if (op_count !== 32'd0 || exp_cnt !== 32'd0) begin bad++; $display("FAIL wrap op_count=%h exp=00000000", op_count); end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_matrix(0, 5'd17);
    test_matrix(2, 5'd30);
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
